// File: rtl/target_lock_controller.sv
// target_lock_controller: keyboard-driven lock-on sequencer between the red
// trackers and the pixel mixer / predictor. Samples the selected target once
// per video frame, tracks missed frames and reports lock status.
module target_lock_controller #(
    parameter int LOST_FRAMES = 8,
    parameter int HOLD_FRAMES = 30,
    parameter int CENTER_X    = 320,
    parameter int CENTER_Y    = 240,
    parameter int HIT_TOL     = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              v_sync,
    input  logic              key_valid,
    input  logic [7:0]        keyboard_data,
    input  logic [15:0][9:0]  aim_x_all,
    input  logic [15:0][9:0]  aim_y_all,
    input  logic [15:0]       aim_detected_all,
    input  logic [9:0]        aim_x,
    input  logic [9:0]        aim_y,
    input  logic              aim_detected,
    output logic              mode_auto,
    output logic [3:0]        cursor_idx,
    output logic              is_locked,
    output logic [3:0]        locked_idx,
    output logic              lost,
    output logic              center_hit,
    output logic [15:0]       target_x,
    output logic [15:0]       target_y,
    output logic              target_valid
);

    localparam int MW = $clog2(LOST_FRAMES + 1);
    localparam int HW = $clog2(HOLD_FRAMES + 1);

    localparam logic [7:0] KEY_A   = 8'h1C;
    localparam logic [7:0] KEY_M   = 8'h3A;
    localparam logic [7:0] KEY_N   = 8'h31;
    localparam logic [7:0] KEY_SP  = 8'h29;
    localparam logic [7:0] KEY_ESC = 8'h76;

    localparam logic signed [16:0] CX  = 17'(CENTER_X);
    localparam logic signed [16:0] CY  = 17'(CENTER_Y);
    localparam logic signed [16:0] TOL = 17'(HIT_TOL);

    typedef enum logic [1:0] {
        SCAN   = 2'd0,
        LOCKED = 2'd1,
        LOST   = 2'd2
    } state_t;

    state_t          state, state_n;
    logic            mode_n;
    logic [3:0]      cursor_n, locked_n;
    logic [15:0]     tx_n, ty_n;
    logic            tv_n;
    logic [MW-1:0]   miss, miss_n;
    logic [HW-1:0]   hold, hold_n;

    logic            vs_q, frame_tick;
    logic            k_a, k_m, k_n, k_sp, k_esc;
    logic [3:0]      next_slot;
    logic signed [16:0] dx, dy, adx, ady;

    assign is_locked = (state == LOCKED);
    assign lost      = (state == LOST);

    assign k_a   = key_valid && (keyboard_data == KEY_A);
    assign k_m   = key_valid && (keyboard_data == KEY_M);
    assign k_n   = key_valid && (keyboard_data == KEY_N);
    assign k_sp  = key_valid && (keyboard_data == KEY_SP);
    assign k_esc = key_valid && (keyboard_data == KEY_ESC);

    // Registered falling-edge detect of v_sync: one-cycle frame tick.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vs_q       <= 1'b0;
            frame_tick <= 1'b0;
        end else begin
            vs_q       <= v_sync;
            frame_tick <= vs_q & ~v_sync;
        end
    end

    // Nearest detected slot above the cursor, circular; scan far-to-near so
    // the closest hit overrides. Stays on the cursor when nothing else is set.
    always_comb begin
        next_slot = cursor_idx;
        for (int k = 15; k >= 1; k--) begin
            if (aim_detected_all[cursor_idx + 4'(k)])
                next_slot = cursor_idx + 4'(k);
        end
    end

    // Next-state and next-output logic. Mode keys dominate; in auto mode the
    // FSM parks in SCAN and only the frame sample runs.
    always_comb begin
        state_n  = state;
        mode_n   = mode_auto;
        cursor_n = cursor_idx;
        locked_n = locked_idx;
        tx_n     = target_x;
        ty_n     = target_y;
        tv_n     = target_valid;
        miss_n   = miss;
        hold_n   = hold;

        if (k_a && !mode_auto) begin
            mode_n  = 1'b1;
            state_n = SCAN;
            tv_n    = 1'b0;
        end else if (k_m && mode_auto) begin
            mode_n  = 1'b0;
            state_n = SCAN;
            tv_n    = 1'b0;
        end else if (mode_auto) begin
            state_n = SCAN;
            if (frame_tick) begin
                tx_n = {6'b0, aim_x};
                ty_n = {6'b0, aim_y};
                tv_n = aim_detected;
            end
        end else begin
            case (state)
                SCAN: begin
                    tv_n = 1'b0;
                    if (k_n) begin
                        cursor_n = next_slot;
                    end else if (k_sp && aim_detected_all[cursor_idx]) begin
                        state_n  = LOCKED;
                        locked_n = cursor_idx;
                    end
                end
                LOCKED: begin
                    if (k_esc) begin
                        state_n = SCAN;
                        tv_n    = 1'b0;
                    end else if (frame_tick) begin
                        if (aim_detected_all[locked_idx]) begin
                            tx_n   = {6'b0, aim_x_all[locked_idx]};
                            ty_n   = {6'b0, aim_y_all[locked_idx]};
                            tv_n   = 1'b1;
                            miss_n = '0;
                        end else begin
                            tv_n = 1'b0;
                            if (int'(miss) >= LOST_FRAMES - 1)
                                state_n = LOST;
                            else
                                miss_n = miss + MW'(1);
                        end
                    end
                end
                LOST: begin
                    tv_n = 1'b0;
                    if (k_esc) begin
                        state_n = SCAN;
                    end else if (frame_tick) begin
                        if (aim_detected_all[locked_idx]) begin
                            state_n = LOCKED;
                            tx_n    = {6'b0, aim_x_all[locked_idx]};
                            ty_n    = {6'b0, aim_y_all[locked_idx]};
                            tv_n    = 1'b1;
                        end else if (int'(hold) >= HOLD_FRAMES - 1) begin
                            state_n = SCAN;
                        end else begin
                            hold_n = hold + HW'(1);
                        end
                    end
                end
                default: begin
                    state_n = SCAN;
                    tv_n    = 1'b0;
                end
            endcase
        end

        // Every state change restarts both frame counters.
        if (state_n != state) begin
            miss_n = '0;
            hold_n = '0;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= SCAN;
            mode_auto    <= 1'b0;
            cursor_idx   <= '0;
            locked_idx   <= '0;
            target_x     <= '0;
            target_y     <= '0;
            target_valid <= 1'b0;
            miss         <= '0;
            hold         <= '0;
        end else begin
            state        <= state_n;
            mode_auto    <= mode_n;
            cursor_idx   <= cursor_n;
            locked_idx   <= locked_n;
            target_x     <= tx_n;
            target_y     <= ty_n;
            target_valid <= tv_n;
            miss         <= miss_n;
            hold         <= hold_n;
        end
    end

    // Centre-window distance from the registered target, signed 17-bit.
    always_comb begin
        dx  = $signed({1'b0, target_x}) - CX;
        dy  = $signed({1'b0, target_y}) - CY;
        adx = (dx < 0) ? -dx : dx;
        ady = (dy < 0) ? -dy : dy;
    end

    // center_hit lags the target registers by one cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            center_hit <= 1'b0;
        else
            center_hit <= is_locked & target_valid & (adx <= TOL) & (ady <= TOL);
    end

endmodule

// File: tb/tb_target_lock_controller.sv
// tb_target_lock_controller: directed plus randomized stimulus against an
// event-level reference model of the lock-on rules.
module tb_target_lock_controller;

    localparam int LOSTF = 8;
    localparam int HOLDF = 30;

    localparam logic [7:0] KA = 8'h1C, KM = 8'h3A, KN = 8'h31, KSP = 8'h29, KESC = 8'h76;
    localparam int S_SCAN = 0, S_LOCK = 1, S_LOST = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic              v_sync;
    logic              key_valid;
    logic [7:0]        keyboard_data;
    logic [15:0][9:0]  aim_x_all, aim_y_all;
    logic [15:0]       aim_detected_all;
    logic [9:0]        aim_x, aim_y;
    logic              aim_detected;
    logic              mode_auto, is_locked, lost, center_hit, target_valid;
    logic [3:0]        cursor_idx, locked_idx;
    logic [15:0]       target_x, target_y;

    int checks = 0;
    int failures = 0;

    // reference model
    int m_mode, m_cur, m_st, m_lidx, m_miss, m_hold, m_tv, m_tx, m_ty;
    int sx[16], sy[16];

    target_lock_controller dut (
        .clk(clk), .reset(reset), .v_sync(v_sync), .key_valid(key_valid),
        .keyboard_data(keyboard_data), .aim_x_all(aim_x_all), .aim_y_all(aim_y_all),
        .aim_detected_all(aim_detected_all), .aim_x(aim_x), .aim_y(aim_y),
        .aim_detected(aim_detected), .mode_auto(mode_auto), .cursor_idx(cursor_idx),
        .is_locked(is_locked), .locked_idx(locked_idx), .lost(lost),
        .center_hit(center_hit), .target_x(target_x), .target_y(target_y),
        .target_valid(target_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    task automatic m_reset();
        m_mode = 0; m_cur = 0; m_st = S_SCAN; m_lidx = 0;
        m_miss = 0; m_hold = 0; m_tv = 0; m_tx = 0; m_ty = 0;
    endtask

    task automatic m_key(input logic [7:0] k);
        if (k == KA) begin
            if (m_mode == 0) begin m_mode = 1; m_st = S_SCAN; m_tv = 0; m_miss = 0; m_hold = 0; end
        end else if (k == KM) begin
            if (m_mode == 1) begin m_mode = 0; m_st = S_SCAN; m_tv = 0; m_miss = 0; m_hold = 0; end
        end else if (m_mode == 0) begin
            if (m_st == S_SCAN && k == KN) begin
                for (int d = 1; d < 16; d++)
                    if (aim_detected_all[(m_cur + d) % 16]) begin m_cur = (m_cur + d) % 16; break; end
            end else if (m_st == S_SCAN && k == KSP && aim_detected_all[m_cur]) begin
                m_st = S_LOCK; m_lidx = m_cur; m_miss = 0; m_hold = 0;
            end else if (m_st != S_SCAN && k == KESC) begin
                m_st = S_SCAN; m_tv = 0; m_miss = 0; m_hold = 0;
            end
        end
    endtask

    task automatic m_frame();
        if (m_mode == 1) begin
            m_tx = aim_x; m_ty = aim_y; m_tv = aim_detected;
        end else if (m_st == S_LOCK) begin
            if (aim_detected_all[m_lidx]) begin
                m_tx = sx[m_lidx]; m_ty = sy[m_lidx]; m_tv = 1; m_miss = 0;
            end else begin
                m_tv = 0; m_miss++;
                if (m_miss >= LOSTF) begin m_st = S_LOST; m_miss = 0; m_hold = 0; end
            end
        end else if (m_st == S_LOST) begin
            if (aim_detected_all[m_lidx]) begin
                m_st = S_LOCK; m_tx = sx[m_lidx]; m_ty = sy[m_lidx]; m_tv = 1; m_hold = 0;
            end else begin
                m_hold++;
                if (m_hold >= HOLDF) begin m_st = S_SCAN; m_hold = 0; end
            end
        end
    endtask

    task automatic check_all(input string tag);
        int hit;
        hit = (m_st == S_LOCK && m_tv == 1 && iabs(m_tx - 320) <= 8 && iabs(m_ty - 240) <= 8) ? 1 : 0;
        chk({tag, ".mode"},   32'(mode_auto),    32'(m_mode));
        chk({tag, ".cursor"}, 32'(cursor_idx),   32'(m_cur));
        chk({tag, ".locked"}, 32'(is_locked),    32'(m_st == S_LOCK));
        chk({tag, ".lidx"},   32'(locked_idx),   32'(m_lidx));
        chk({tag, ".lost"},   32'(lost),         32'(m_st == S_LOST));
        chk({tag, ".tx"},     32'(target_x),     32'(m_tx));
        chk({tag, ".ty"},     32'(target_y),     32'(m_ty));
        chk({tag, ".tv"},     32'(target_valid), 32'(m_tv));
        chk({tag, ".hit"},    32'(center_hit),   32'(hit));
    endtask

    task automatic load_slots();
        for (int i = 0; i < 16; i++) begin
            aim_x_all[i] = sx[i][9:0];
            aim_y_all[i] = sy[i][9:0];
        end
    endtask

    task automatic press(input logic [7:0] k, input string tag);
        @(posedge clk); #1;
        key_valid = 1'b1; keyboard_data = k;
        @(posedge clk); #1;
        key_valid = 1'b0;
        m_key(k);
        @(posedge clk);
        @(negedge clk);
        check_all(tag);
    endtask

    task automatic frame(input string tag);
        @(posedge clk); #1;
        v_sync = 1'b0;
        repeat (3) @(posedge clk);
        #1 v_sync = 1'b1;
        m_frame();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_all(tag);
    endtask

    // key strobe lands on the same cycle as the frame tick
    task automatic key_tick(input logic [7:0] k, input string tag);
        int st0, md0;
        @(posedge clk); #1;
        v_sync = 1'b0;
        @(posedge clk); #1;
        key_valid = 1'b1; keyboard_data = k;
        @(posedge clk); #1;
        key_valid = 1'b0; v_sync = 1'b1;
        st0 = m_st; md0 = m_mode;
        m_key(k);
        if (st0 == m_st && md0 == m_mode) m_frame();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_all(tag);
    endtask

    initial begin
        logic [7:0] keys [6];
        int bias;
        keys[0] = KA; keys[1] = KM; keys[2] = KN; keys[3] = KSP; keys[4] = KESC; keys[5] = 8'h55;

        reset = 1'b0; v_sync = 1'b1; key_valid = 1'b0; keyboard_data = 8'h00;
        aim_detected_all = '0; aim_x = '0; aim_y = '0; aim_detected = 1'b0;
        for (int i = 0; i < 16; i++) begin sx[i] = 0; sy[i] = 0; end
        load_slots();
        m_reset();
        #12 check_all("reset");
        @(posedge clk); #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk) check_all("post_reset");

        // cursor stepping with wrap
        aim_detected_all = 16'h0024;
        press(KN, "n1");
        chk("n1.cur2", 32'(cursor_idx), 32'd2);
        press(KN, "n2");
        chk("n2.cur5", 32'(cursor_idx), 32'd5);
        press(KN, "n3");
        press(KN, "n4");

        // lock onto slot 5 and sample it
        sx[5] = 330; sy[5] = 236; load_slots();
        press(KSP, "lock");
        frame("lock_f1");
        sx[5] = 324; load_slots();
        frame("hit_f");
        sx[5] = 340; sy[5] = 240; load_slots();
        frame("miss_win_f");

        // miss frames into LOST, reacquire at frame 10
        aim_detected_all = 16'h0000;
        for (int f = 1; f <= 9; f++) frame($sformatf("miss%0d", f));
        aim_detected_all = 16'h0024; sx[5] = 318; sy[5] = 242; load_slots();
        frame("reacq");

        // lose it and hold until SCAN
        aim_detected_all = 16'h0000;
        for (int f = 1; f <= LOSTF + HOLDF; f++) frame($sformatf("hold%0d", f));

        // Esc together with a frame tick: target must not update
        aim_detected_all = 16'h0024;
        press(KSP, "relock");
        frame("relock_f");
        sx[5] = 500; sy[5] = 400; load_slots();
        key_tick(KESC, "esc_tick");

        // switch to auto while locked
        press(KSP, "relock2");
        frame("relock2_f");
        press(KA, "auto");
        aim_x = 10'd100; aim_y = 10'd50; aim_detected = 1'b1;
        frame("auto_f");
        press(KSP, "auto_sp");
        press(KA, "auto_again");

        // randomized phase
        for (int it = 0; it < 400; it++) begin
            int r;
            bias = ((it / 40) % 2) ? 15 : 85;
            r = $urandom_range(0, 9);
            aim_detected_all = 16'($urandom);
            if ($urandom_range(0, 99) < bias) aim_detected_all[m_lidx] = 1'b1;
            else aim_detected_all[m_lidx] = 1'b0;
            for (int i = 0; i < 16; i++) begin
                sx[i] = 305 + $urandom_range(0, 30);
                sy[i] = 225 + $urandom_range(0, 30);
            end
            load_slots();
            aim_x = 10'($urandom); aim_y = 10'($urandom); aim_detected = 1'($urandom);
            if (r <= 3)      frame($sformatf("rnd%0d.frame", it));
            else if (r <= 8) press(keys[$urandom_range(0, 5)], $sformatf("rnd%0d.key", it));
            else             key_tick(keys[$urandom_range(0, 5)], $sformatf("rnd%0d.kt", it));
        end

        // reset asynchronously while locked
        press(KM, "pre_rst_m");
        aim_detected_all = 16'hFFFF; sx[m_cur] = 320; sy[m_cur] = 240; load_slots();
        press(KSP, "pre_rst_lock");
        frame("pre_rst_f");
        chk("pre_rst.locked", 32'(is_locked), 32'd1);
        #2 reset = 1'b0;
        m_reset();
        #1 check_all("async_rst");
        @(posedge clk); #1 reset = 1'b1;
        @(negedge clk) check_all("rst_release");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
